// File: rtl/bus_xcvr_pkg.sv
// Shared types and constants for the bus transceiver enable controller.
package bus_xcvr_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StDrive,
      StRelease
   } state_t;

   localparam logic AB = 1'b1;
   localparam logic BA = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last winner.
module rr_arbiter #(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0]         i_req,
   input  logic [$clog2(N)-1:0] i_last_winner,
   output logic [N-1:0]         o_gnt,
   output logic [$clog2(N)-1:0] o_idx
);

   localparam int unsigned IW = $clog2(N);

   always_comb begin
      int unsigned j;
      o_gnt = '0;
      o_idx = '0;
      j     = 0;
      // Scan farthest-first so the nearest requester after the pointer overwrites last.
      for (int unsigned k = N; k >= 1; k--) begin
         j = (32'(i_last_winner) + k) % N;
         if (i_req[j]) begin
            o_gnt = N'(1) << j;
            o_idx = IW'(j);
         end
      end
   end

endmodule

// File: rtl/bus_xcvr_ctrl.sv
// Sequences DIR/nOE for N ttl_74245 transceivers sharing one bus segment.
// Define BUS_XCVR_CTRL_CONTENTION_CHECK_EN to build the sticky contention monitor on err.
module bus_xcvr_ctrl
   import bus_xcvr_pkg::*;
#(
   parameter int unsigned N           = 2,
   parameter int unsigned DEAD_CYCLES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic [N-1:0] dir_req,
   output logic [N-1:0] nOE,
   output logic [N-1:0] DIR,
   output logic [N-1:0] gnt,
   output logic         busy,
   output logic         err
);

   localparam int unsigned   IW      = $clog2(N);
   localparam int unsigned   CW      = $clog2(DEAD_CYCLES + 1);
   localparam logic [CW-1:0] CntLoad = CW'(DEAD_CYCLES - 1);

   state_t        r_state, w_state_next;
   logic [CW-1:0] r_cnt;
   logic [IW-1:0] r_last, r_w, w_arb_idx;
   logic [N-1:0]  r_noe, r_dir, w_arb_gnt;
   logic          w_cnt_zero, w_arb_valid;

   rr_arbiter #(
      .N(N)
   ) u_arb (
      .i_req        (req),
      .i_last_winner(r_last),
      .o_gnt        (w_arb_gnt),
      .o_idx        (w_arb_idx)
   );

   assign w_arb_valid = |w_arb_gnt;
   assign w_cnt_zero  = (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (reset) r_state <= StIdle;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle:    if (w_arb_valid) w_state_next = StSetup;
         // Nothing was enabled yet, so an abandoned setup needs no dead time.
         StSetup:   if (!req[r_w]) w_state_next = StIdle;
                    else if (w_cnt_zero) w_state_next = StDrive;
         StDrive:   if (!req[r_w] || (dir_req[r_w] != r_dir[r_w])) w_state_next = StRelease;
         StRelease: if (w_cnt_zero) w_state_next = StIdle;
         default:   w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= '0;
         r_last <= IW'(N - 1);
         r_w    <= '0;
         r_noe  <= '1;
         r_dir  <= {N{BA}};
      end else if (r_state == StIdle && w_state_next == StSetup) begin
         r_w               <= w_arb_idx;
         r_last            <= w_arb_idx;
         r_dir[w_arb_idx]  <= (dir_req[w_arb_idx] == AB) ? AB : BA;
         r_cnt             <= CntLoad;
      end else if (r_state == StSetup && w_state_next == StDrive) begin
         r_noe[r_w] <= 1'b0;
      end else if (r_state == StDrive && w_state_next == StRelease) begin
         r_noe <= '1;
         r_cnt <= CntLoad;
      end else if ((r_state == StSetup || r_state == StRelease) && !w_cnt_zero) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   always_comb begin
      nOE  = r_noe;
      DIR  = r_dir;
      gnt  = ~r_noe;
      busy = (r_state != StIdle);
   end

`ifdef BUS_XCVR_CTRL_CONTENTION_CHECK_EN
   logic [N-1:0] w_mon_noe, w_mon_low, r_mon_noe, r_mon_dir;
   logic         r_err, w_multi, w_dir_hot;

   assign w_mon_noe = r_noe;
   assign w_mon_low = ~w_mon_noe;
   assign w_multi   = (w_mon_low & (w_mon_low - N'(1))) != '0;
   // A DIR edge is illegal if nOE was low before it or is low after it.
   assign w_dir_hot = ((r_dir ^ r_mon_dir) & (w_mon_low | ~r_mon_noe)) != '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_err     <= 1'b0;
         r_mon_noe <= '1;
         r_mon_dir <= '0;
      end else begin
         r_mon_noe <= w_mon_noe;
         r_mon_dir <= r_dir;
         if (w_multi || w_dir_hot) r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule
